// File: rtl/neuron_pkg.sv
// neuron_pkg: shared state encoding and pipeline depths for the neuron layer sequencer
package neuron_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
  localparam int RD_LAT = 1;
  localparam int NEURON_LAT = 2;
  localparam int N_DEF = 8;
endpackage

// File: rtl/seq_valid_pipe.sv
// seq_valid_pipe: valid shift register, bit 0 is one cycle after i_valid
module seq_valid_pipe #(
  parameter int DEPTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  output logic [DEPTH-1:0] o_v
);
  logic [DEPTH-1:0] r_v;
  always_ff @(posedge clk)
    r_v <= rst ? '0 : {r_v[DEPTH-2:0], i_valid};
  assign o_v = r_v;
endmodule

// File: rtl/neuron_layer_seq.sv
// neuron_layer_seq: runs one neuron datapath over a layer; NEURON_LAYER_SEQ_PERF_EN adds o_cycle_count
module neuron_layer_seq
  import neuron_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int N_NEURONS = 16,
  parameter int ADDR_W = $clog2(N_NEURONS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic [ADDR_W:0]   i_n_neurons_cfg,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_w_rd_en,
  output logic [ADDR_W-1:0] o_w_addr,
  output logic              o_neuron_en,
  input  logic [N-1:0]      i_neuron_out,
  output logic              o_res_we,
  output logic [ADDR_W-1:0] o_res_addr,
  output logic [N-1:0]      o_res_data
`ifdef NEURON_LAYER_SEQ_PERF_EN
  , output logic [31:0]     o_cycle_count
`endif
);
  localparam int DEPTH = RD_LAT + NEURON_LAT;
  localparam logic [ADDR_W:0] C_ONE = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] C_MAX = (ADDR_W+1)'(N_NEURONS);
  state_t r_state, w_next;
  logic [ADDR_W:0] r_cnt;
  logic [ADDR_W-1:0] r_issue_idx, r_wr_idx;
  logic [DEPTH-1:0] w_v;
  logic w_accept, w_last_issue, w_last_wr;
  assign w_accept = r_state == IDLE && i_start;
  assign w_last_issue = {1'b0, r_issue_idx} == r_cnt - C_ONE;
  assign w_last_wr = {1'b0, r_wr_idx} == r_cnt - C_ONE;
  always_comb begin
    w_next = r_state == IDLE  ? (i_start ? (i_n_neurons_cfg == '0 ? DONE : ISSUE) : IDLE)
           : r_state == ISSUE ? (w_last_issue ? DRAIN : ISSUE)
           : r_state == DRAIN ? (o_res_we && w_last_wr ? DONE : DRAIN)
           : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_issue_idx <= '0;
      r_wr_idx    <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_cnt       <= i_n_neurons_cfg > C_MAX ? C_MAX : i_n_neurons_cfg;
        r_issue_idx <= '0;
        r_wr_idx    <= '0;
      end else begin
        if (r_state == ISSUE && !w_last_issue) r_issue_idx <= r_issue_idx + ADDR_W'(1);
        if (o_res_we) r_wr_idx <= r_wr_idx + ADDR_W'(1);
      end
    end
  end
  seq_valid_pipe #(.DEPTH(DEPTH)) u_pipe (
    .clk     (clk),
    .rst     (rst),
    .i_valid (o_w_rd_en),
    .o_v     (w_v)
  );
  // the extra enable after the last weight row flushes acc into the output register
  assign o_neuron_en = |w_v[NEURON_LAT-1:0];
  assign o_res_we    = w_v[DEPTH-1];
  assign o_busy      = r_state == ISSUE || r_state == DRAIN;
  assign o_done      = r_state == DONE;
  assign o_w_rd_en   = r_state == ISSUE;
  assign o_w_addr    = r_issue_idx;
  assign o_res_addr  = r_wr_idx;
  assign o_res_data  = i_neuron_out;
`ifdef NEURON_LAYER_SEQ_PERF_EN
  logic [31:0] r_cycle_count;
  always_ff @(posedge clk)
    if (rst || w_accept) r_cycle_count <= '0;
    else if (r_state != IDLE && r_cycle_count != '1) r_cycle_count <= r_cycle_count + 32'd1;
  assign o_cycle_count = r_cycle_count;
`endif
endmodule

// File: tb/tb_neuron_layer_seq.sv
// tb_neuron_layer_seq: directed table-driven bench for neuron_layer_seq with a behavioural neuron and weight memory
module tb_neuron_layer_seq;
  logic clk, rst, i_start;
  logic [4:0] i_n_neurons_cfg;
  logic o_busy, o_done, o_w_rd_en, o_neuron_en, o_res_we;
  logic [3:0] o_w_addr, o_res_addr;
  logic [7:0] i_neuron_out, o_res_data;
`ifdef NEURON_LAYER_SEQ_PERF_EN
  logic [31:0] o_cycle_count;
`endif
  int n_cmp = 0;
  int n_bad = 0;
  int pre [16];
  int r_w, r_acc;
  logic [7:0] r_out;

  neuron_layer_seq dut (
    .clk             (clk),
    .rst             (rst),
    .i_start         (i_start),
    .i_n_neurons_cfg (i_n_neurons_cfg),
    .o_busy          (o_busy),
    .o_done          (o_done),
    .o_w_rd_en       (o_w_rd_en),
    .o_w_addr        (o_w_addr),
    .o_neuron_en     (o_neuron_en),
    .i_neuron_out    (i_neuron_out),
    .o_res_we        (o_res_we),
    .o_res_addr      (o_res_addr),
    .o_res_data      (o_res_data)
`ifdef NEURON_LAYER_SEQ_PERF_EN
    , .o_cycle_count (o_cycle_count)
`endif
  );

  initial clk = 0;
  always #5 clk = ~clk;

  function automatic logic [7:0] relu(input int x);
    return x < 0 ? 8'd0 : x > 127 ? 8'd127 : 8'(x);
  endfunction

  // weight memory returns the row's pre-activation one cycle after the read; neuron is acc then out
  always @(posedge clk) begin
    if (rst) begin
      r_w <= 0;
      r_acc <= 0;
      r_out <= '0;
    end else begin
      if (o_w_rd_en) r_w <= pre[o_w_addr];
      if (o_neuron_en) begin
        r_acc <= r_w;
        r_out <= relu(r_acc);
      end
    end
  end
  assign i_neuron_out = r_out;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " busy"}, o_busy, 0);
    chk({tag, " done"}, o_done, 0);
    chk({tag, " w_rd_en"}, o_w_rd_en, 0);
    chk({tag, " neuron_en"}, o_neuron_en, 0);
    chk({tag, " res_we"}, o_res_we, 0);
    chk({tag, " w_addr"}, o_w_addr, 0);
    chk({tag, " res_addr"}, o_res_addr, 0);
  endtask

  task automatic run_vec(input int cfg, input int k, input bit repulse);
    int n_we = 0;
    int t_done = k > 0 ? k + 4 : 1;
    @(negedge clk);
    i_start = 1;
    i_n_neurons_cfg = 5'(cfg);
    for (int c = 1; c <= k + 6; c++) begin
      @(negedge clk);
      i_start = repulse && (c == 2 || c == 5);
      chk("w_rd_en", o_w_rd_en, int'(c <= k));
      if (c <= k) chk("w_addr", o_w_addr, c - 1);
      chk("neuron_en", o_neuron_en, int'(k > 0 && c >= 2 && c <= k + 2));
      chk("res_we", o_res_we, int'(c >= 4 && c <= k + 3));
      if (o_res_we) begin
        n_we++;
        chk("res_addr", o_res_addr, c - 4);
        chk("res_data", o_res_data, relu(pre[(c - 4) % 16]));
      end
      chk("busy", o_busy, int'(k > 0 && c <= k + 3));
      chk("done", o_done, int'(c == t_done));
    end
    chk("write_count", n_we, k);
`ifdef NEURON_LAYER_SEQ_PERF_EN
    chk("cycle_count", o_cycle_count, t_done);
    repeat (3) @(negedge clk);
    chk("cycle_count_held", o_cycle_count, t_done);
`endif
  endtask

  typedef struct {
    int cfg;
    int k;
    bit repulse;
  } vec_t;
  vec_t vecs [7];

  initial begin
    pre = '{5, -3, 200, 0, 10, -1, 127, 128, 1, 2, 3, 4, 60, -128, 300, 7};
    vecs[0] = '{4, 4, 0};
    vecs[1] = '{0, 0, 0};
    vecs[2] = '{31, 16, 0};
    vecs[3] = '{4, 4, 1};
    vecs[4] = '{16, 16, 0};
    vecs[5] = '{1, 1, 0};
    vecs[6] = '{17, 16, 0};
    rst = 1;
    i_start = 0;
    i_n_neurons_cfg = '0;
    repeat (3) @(negedge clk);
    i_start = 1;
    i_n_neurons_cfg = 5'd4;
    @(negedge clk);
    chk_idle("reset");
`ifdef NEURON_LAYER_SEQ_PERF_EN
    chk("reset cycle_count", o_cycle_count, 0);
`endif
    rst = 0;
    i_start = 0;
    @(negedge clk);
    chk_idle("after_reset");
    foreach (vecs[i]) run_vec(vecs[i].cfg, vecs[i].k, vecs[i].repulse);
    // abort a cfg=8 run with rst at s+3, with a start raised alongside it
    @(negedge clk);
    i_start = 1;
    i_n_neurons_cfg = 5'd8;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c <= 3) begin
        chk("abort w_rd_en", o_w_rd_en, 1);
        chk("abort w_addr", o_w_addr, c - 1);
        chk("abort busy", o_busy, 1);
      end else chk_idle("abort");
      i_start = c == 3;
      rst = c == 3;
    end
    run_vec(2, 2, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
